// File: rtl/ofdm_frame_gate_pkg.sv
// Shared definitions for the OFDM frame gate: register map, FSM encoding and
// status word layout.
package ofdm_frame_gate_pkg;

  localparam int unsigned REG_SYM_LEN  = 0;
  localparam int unsigned REG_NUM_SYMS = 1;
  localparam int unsigned REG_HOLDOFF  = 2;
  localparam int unsigned REG_CTRL     = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StActive  = 2'd1,
    StHoldoff = 2'd2
  } state_e;

  localparam int unsigned RB_STATE_LSB     = 0;
  localparam int unsigned RB_BUSY_BIT      = 2;
  localparam int unsigned RB_ENABLE_BIT    = 3;
  localparam int unsigned RB_DROPPED_LSB   = 16;
  localparam int unsigned RB_FRAME_CNT_LSB = 32;

  // Last index of a count where a programmed zero behaves as one.
  function automatic logic [15:0] last_idx16(input logic [15:0] n);
    return (n == 16'd0) ? 16'd0 : n - 16'd1;
  endfunction

  function automatic logic [7:0] last_idx8(input logic [7:0] n);
    return (n == 8'd0) ? 8'd0 : n - 8'd1;
  endfunction

endpackage

// File: rtl/axi_fifo_flop.sv
// Single-entry AXI-stream register stage with full throughput when the sink
// is ready; synchronous clear flushes the held beat.
module axi_fifo_flop #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign i_tready = ~valid_q | o_tready;
  assign o_tdata  = data_q;
  assign o_tvalid = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (i_tvalid && i_tready) begin
      data_d  = i_tdata;
      valid_d = 1'b1;
    end else if (o_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/ofdm_frame_gate.sv
// Frame sequencer after the Schmidl-Cox detector: forwards num_syms symbols of
// sym_len samples per trigger, marks symbol ends, then enforces a holdoff.
module ofdm_frame_gate
  import ofdm_frame_gate_pkg::*;
#(
  parameter int unsigned BASE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  output logic [63:0] rb_data,
  input  logic [31:0] i_tdata,
  input  logic        i_tuser,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tuser,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);

  logic [15:0] sym_len_q, sym_len_d, holdoff_q, holdoff_d;
  logic [7:0]  num_syms_q, num_syms_d;
  logic        enable_q, enable_d, clear_q, clear_d;
  state_e      state_q, state_d;
  logic [15:0] samp_cnt_q, samp_cnt_d, hold_cnt_q, hold_cnt_d;
  logic [7:0]  sym_cnt_q, sym_cnt_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic [15:0] dropped_q, dropped_d;
  logic [15:0] sh_samp_last_q, sh_samp_last_d, sh_holdoff_q, sh_holdoff_d;
  logic [7:0]  sh_sym_last_q, sh_sym_last_d;

  logic        fifo_in_ready, trig_start, pass, beat, fwd, sym_end, frame_end;
  logic [15:0] cur_samp, samp_last, hold_eff;
  logic [7:0]  cur_sym, sym_last;
  logic [33:0] fifo_out;
  logic        unused_inputs;

  assign unused_inputs = ^{i_tlast, set_data[31:16]};

  // The trigger beat is evaluated against the live config, which the shadows
  // receive on the same edge, so a one-beat frame closes immediately.
  assign trig_start = (state_q == StIdle) & i_tuser & enable_q;
  assign pass       = (state_q == StActive) | trig_start;
  assign i_tready   = reset_n & (pass ? fifo_in_ready : 1'b1);
  assign beat       = i_tvalid & i_tready;
  assign fwd        = beat & pass & ~clear_q;
  assign cur_samp   = trig_start ? 16'd0 : samp_cnt_q;
  assign cur_sym    = trig_start ? 8'd0 : sym_cnt_q;
  assign samp_last  = trig_start ? last_idx16(sym_len_q) : sh_samp_last_q;
  assign sym_last   = trig_start ? last_idx8(num_syms_q) : sh_sym_last_q;
  assign hold_eff   = trig_start ? holdoff_q : sh_holdoff_q;
  assign sym_end    = (cur_samp == samp_last);
  assign frame_end  = sym_end & (cur_sym == sym_last);

  axi_fifo_flop #(
    .WIDTH(34)
  ) u_out_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_q),
    .i_tdata ({trig_start, sym_end, i_tdata}),
    .i_tvalid(fwd),
    .i_tready(fifo_in_ready),
    .o_tdata (fifo_out),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready)
  );

  assign o_tuser = fifo_out[33];
  assign o_tlast = fifo_out[32];
  assign o_tdata = fifo_out[31:0];

  always_comb begin
    rb_data = '0;
    rb_data[RB_STATE_LSB +: 2]      = state_q;
    rb_data[RB_BUSY_BIT]            = (state_q != StIdle) | o_tvalid;
    rb_data[RB_ENABLE_BIT]          = enable_q;
    rb_data[RB_DROPPED_LSB +: 16]   = dropped_q;
    rb_data[RB_FRAME_CNT_LSB +: 32] = frame_count_q;
  end

  always_comb begin
    sym_len_d      = sym_len_q;
    num_syms_d     = num_syms_q;
    holdoff_d      = holdoff_q;
    enable_d       = enable_q;
    clear_d        = 1'b0;
    state_d        = state_q;
    samp_cnt_d     = samp_cnt_q;
    sym_cnt_d      = sym_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    frame_count_d  = frame_count_q;
    dropped_d      = dropped_q;
    sh_samp_last_d = sh_samp_last_q;
    sh_sym_last_d  = sh_sym_last_q;
    sh_holdoff_d   = sh_holdoff_q;

    if (set_stb) begin
      if (set_addr == 8'(BASE + REG_SYM_LEN))  sym_len_d  = set_data[15:0];
      if (set_addr == 8'(BASE + REG_NUM_SYMS)) num_syms_d = set_data[7:0];
      if (set_addr == 8'(BASE + REG_HOLDOFF))  holdoff_d  = set_data[15:0];
      if (set_addr == 8'(BASE + REG_CTRL)) begin
        enable_d = set_data[0];
        clear_d  = set_data[1];
      end
    end

    if (clear_q) begin
      state_d       = StIdle;
      samp_cnt_d    = '0;
      sym_cnt_d     = '0;
      hold_cnt_d    = '0;
      frame_count_d = '0;
      dropped_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (beat && trig_start) begin
            sh_samp_last_d = samp_last;
            sh_sym_last_d  = sym_last;
            sh_holdoff_d   = holdoff_q;
          end
        end
        StActive, StHoldoff: begin
          if (beat && i_tuser && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
          if (beat && state_q == StHoldoff) begin
            if (hold_cnt_q == sh_holdoff_q - 16'd1) begin
              state_d    = StIdle;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (fwd) begin
        if (frame_end) begin
          frame_count_d = frame_count_q + 32'd1;
          samp_cnt_d    = '0;
          sym_cnt_d     = '0;
          hold_cnt_d    = '0;
          state_d       = (hold_eff == 16'd0) ? StIdle : StHoldoff;
        end else if (sym_end) begin
          samp_cnt_d = '0;
          sym_cnt_d  = cur_sym + 8'd1;
          state_d    = StActive;
        end else begin
          samp_cnt_d = cur_samp + 16'd1;
          sym_cnt_d  = cur_sym;
          state_d    = StActive;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_len_q      <= '0;
      num_syms_q     <= '0;
      holdoff_q      <= '0;
      enable_q       <= 1'b0;
      clear_q        <= 1'b0;
      state_q        <= StIdle;
      samp_cnt_q     <= '0;
      sym_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      frame_count_q  <= '0;
      dropped_q      <= '0;
      sh_samp_last_q <= '0;
      sh_sym_last_q  <= '0;
      sh_holdoff_q   <= '0;
    end else begin
      sym_len_q      <= sym_len_d;
      num_syms_q     <= num_syms_d;
      holdoff_q      <= holdoff_d;
      enable_q       <= enable_d;
      clear_q        <= clear_d;
      state_q        <= state_d;
      samp_cnt_q     <= samp_cnt_d;
      sym_cnt_q      <= sym_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      frame_count_q  <= frame_count_d;
      dropped_q      <= dropped_d;
      sh_samp_last_q <= sh_samp_last_d;
      sh_sym_last_q  <= sh_sym_last_d;
      sh_holdoff_q   <= sh_holdoff_d;
    end
  end

endmodule

// File: tb/tb_ofdm_frame_gate.sv
// Directed bench for ofdm_frame_gate: ramp stimulus with programmed triggers,
// output beats collected and compared against hand-derived frame layouts.
module tb_ofdm_frame_gate;
  import ofdm_frame_gate_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [63:0] rb_data;
  logic [31:0] i_tdata;
  logic        i_tuser, i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic        o_tuser, o_tlast, o_tvalid, o_tready;

  always #5 clk = ~clk;

  ofdm_frame_gate #(
    .BASE(0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .set_stb (set_stb),
    .set_addr(set_addr),
    .set_data(set_data),
    .rb_data (rb_data),
    .i_tdata (i_tdata),
    .i_tuser (i_tuser),
    .i_tlast (i_tlast),
    .i_tvalid(i_tvalid),
    .i_tready(i_tready),
    .o_tdata (o_tdata),
    .o_tuser (o_tuser),
    .o_tlast (o_tlast),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q_data[$];
  bit          q_user[$];
  bit          q_last[$];
  bit          trig[0:1023];
  int          idx;
  bit          stream_on;
  int          rdy_mode;
  bit          prev_stall;
  logic [33:0] prev_out;
  int          stall_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, observe both handshakes at the negedge, advance.
  task automatic tick();
    i_tvalid = stream_on;
    i_tdata  = 32'(idx);
    i_tuser  = stream_on && (idx < 1024) && trig[idx];
    case (rdy_mode)
      0:       o_tready = 1'b1;
      1:       o_tready = 1'($urandom_range(0, 1));
      default: o_tready = 1'b0;
    endcase
    @(negedge clk);
    if (prev_stall && (!o_tvalid || {o_tuser, o_tlast, o_tdata} !== prev_out)) stall_err++;
    prev_stall = o_tvalid & ~o_tready;
    prev_out   = {o_tuser, o_tlast, o_tdata};
    if (o_tvalid && o_tready) begin
      q_data.push_back(o_tdata);
      q_user.push_back(o_tuser);
      q_last.push_back(o_tlast);
    end
    if (i_tvalid && i_tready) idx++;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = 8'(addr);
    set_data = data;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic cfg(input int sl, input int ns, input int ho, input int ctrl);
    wr(REG_SYM_LEN, 32'(sl));
    wr(REG_NUM_SYMS, 32'(ns));
    wr(REG_HOLDOFF, 32'(ho));
    wr(REG_CTRL, 32'(ctrl));
  endtask

  task automatic start_stream();
    q_data.delete();
    q_user.delete();
    q_last.delete();
    idx       = 0;
    stream_on = 1'b1;
  endtask

  task automatic clear_trig();
    for (int i = 0; i < 1024; i++) trig[i] = 1'b0;
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (idx < target && n < 5000) begin
      tick();
      n++;
    end
    check("run_budget", 64'(idx >= target), 64'd1);
  endtask

  task automatic drain(input int n);
    stream_on = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_frame(input string tag, input int qoff, input int start,
                             input int slen, input int nsyms);
    int bad = 0;
    for (int k = 0; k < slen * nsyms; k++) begin
      if (qoff + k >= q_data.size()) bad++;
      else if (q_data[qoff+k] !== 32'(start + k) || q_user[qoff+k] != (k == 0) ||
               q_last[qoff+k] != ((k % slen) == slen - 1)) bad++;
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    int nlast;
    reset_n   = 1'b0;
    set_stb   = 1'b0;
    set_addr  = '0;
    set_data  = '0;
    i_tdata   = '0;
    i_tuser   = 1'b0;
    i_tlast   = 1'b0;
    i_tvalid  = 1'b0;
    o_tready  = 1'b1;
    stream_on = 1'b0;
    rdy_mode  = 0;
    idx       = 0;
    stall_err = 0;
    clear_trig();
    repeat (3) @(posedge clk);
    #1;
    check("rst_itready", 64'(i_tready), 64'd0);
    check("rst_rb", rb_data, 64'd0);
    check("rst_ovalid", 64'(o_tvalid), 64'd0);
    reset_n = 1'b1;
    #1;
    check("idle_itready", 64'(i_tready), 64'd1);

    // Basic frame
    cfg(80, 4, 0, 1);
    trig[37] = 1'b1;
    start_stream();
    run_to(420);
    drain(4);
    check("t1_len", 64'(q_data.size()), 64'd320);
    check_frame("t1_frame", 0, 37, 80, 4);
    check("t1_frames", 64'(rb_data[63:32]), 64'd1);
    check("t1_dropped", 64'(rb_data[31:16]), 64'd0);
    check("t1_idle", 64'(rb_data[2:0]), 64'd0);

    // Random backpressure
    rdy_mode   = 1;
    prev_stall = 1'b0;
    start_stream();
    run_to(420);
    rdy_mode = 0;
    drain(6);
    check("t2_len", 64'(q_data.size()), 64'd320);
    check_frame("t2_frame", 0, 37, 80, 4);
    check("t2_stable", 64'(stall_err), 64'd0);
    check("t2_frames", 64'(rb_data[63:32]), 64'd2);

    // Clear, then holdoff with dropped triggers
    wr(REG_CTRL, 32'd3);
    tick();
    check("clr_frames", 64'(rb_data[63:32]), 64'd0);
    cfg(80, 4, 100, 1);
    clear_trig();
    trig[0] = 1'b1; trig[200] = 1'b1; trig[350] = 1'b1; trig[500] = 1'b1;
    start_stream();
    run_to(950);
    drain(4);
    check("t3_len", 64'(q_data.size()), 64'd640);
    check_frame("t3_frame1", 0, 0, 80, 4);
    check_frame("t3_frame2", 320, 500, 80, 4);
    check("t3_dropped", 64'(rb_data[31:16]), 64'd2);
    check("t3_frames", 64'(rb_data[63:32]), 64'd2);
    check("t3_idle", 64'(rb_data[1:0]), 64'd0);

    // Zero config: one-beat frame
    cfg(0, 0, 0, 1);
    clear_trig();
    trig[5] = 1'b1;
    start_stream();
    run_to(20);
    drain(3);
    check("t4_len", 64'(q_data.size()), 64'd1);
    if (q_data.size() > 0) begin
      check("t4_data", 64'(q_data[0]), 64'd5);
      check("t4_user", 64'(q_user[0]), 64'd1);
      check("t4_last", 64'(q_last[0]), 64'd1);
    end
    check("t4_frames", 64'(rb_data[63:32]), 64'd3);

    // sym_len written mid-frame
    cfg(80, 4, 0, 1);
    clear_trig();
    trig[10] = 1'b1; trig[400] = 1'b1;
    start_stream();
    run_to(50);
    wr(REG_SYM_LEN, 32'd64);
    run_to(800);
    drain(4);
    check("t5_len", 64'(q_data.size()), 64'd576);
    check_frame("t5_frame1", 0, 10, 80, 4);
    check_frame("t5_frame2", 320, 400, 64, 4);
    check("t5_frames", 64'(rb_data[63:32]), 64'd5);

    // enable cleared mid-frame
    cfg(80, 4, 0, 1);
    start_stream();
    run_to(50);
    wr(REG_CTRL, 32'd0);
    run_to(800);
    drain(4);
    check("t6_len", 64'(q_data.size()), 64'd320);
    check_frame("t6_frame", 0, 10, 80, 4);
    check("t6_frames", 64'(rb_data[63:32]), 64'd6);
    check("t6_dropped", 64'(rb_data[31:16]), 64'd2);
    check("t6_enable", 64'(rb_data[3]), 64'd0);

    // Reset during symbol 2
    cfg(80, 4, 0, 1);
    clear_trig();
    trig[10] = 1'b1;
    start_stream();
    run_to(190);
    reset_n = 1'b0;
    #2;
    check("t7_ovalid", 64'(o_tvalid), 64'd0);
    check("t7_odata", {31'd0, o_tuser, o_tlast, o_tdata}, 64'd0);
    check("t7_rb", rb_data, 64'd0);
    check("t7_itready", 64'(i_tready), 64'd0);
    nlast = 0;
    foreach (q_last[i]) nlast += int'(q_last[i]);
    check("t7_partial_tlast", 64'(nlast), 64'd2);
    stream_on = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    cfg(80, 4, 0, 1);
    clear_trig();
    trig[20] = 1'b1;
    start_stream();
    run_to(420);
    drain(4);
    check("t7_len", 64'(q_data.size()), 64'd320);
    check_frame("t7_frame", 0, 20, 80, 4);
    check("t7_frames", 64'(rb_data[63:32]), 64'd1);

    // ctrl.clear flushes a stalled output mid-frame
    start_stream();
    run_to(100);
    rdy_mode = 2;
    tick();
    check("t8_stalled", 64'(o_tvalid), 64'd1);
    check("t8_active", 64'(rb_data[1:0]), 64'd1);
    wr(REG_CTRL, 32'd3);
    tick();
    check("t8_ovalid", 64'(o_tvalid), 64'd0);
    check("t8_frames", 64'(rb_data[63:32]), 64'd0);
    check("t8_dropped", 64'(rb_data[31:16]), 64'd0);
    check("t8_idle", 64'(rb_data[1:0]), 64'd0);
    rdy_mode = 0;
    drain(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
